// File: rtl/io_pad_ctrl_if.sv
// io_pad_ctrl_if: Wishbone slave bus between the Caravel management port and
// io_pad_ctrl. Signal names follow the management-port naming (_i/_o as seen
// from the slave).
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe, cycle, write enable
//   wbs_sel_i [3:0]                : byte selects
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_ack_o                      : single-cycle acknowledge
//   wbs_dat_o [31:0]               : read data (valid with ack, else 0)
interface io_pad_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/io_pad_ctrl.sv
// io_pad_ctrl: Wishbone-slave pad/reset controller for the zerosoc core.
// Sequences the SoC core reset (programmable hold then release), lets the host
// override individual pads (output value and OEB), and exposes synchronized
// pad inputs for readback.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   wbs          : Wishbone slave bus (io_pad_ctrl_if.slave)
//   soc_rst_no   : active-low SoC core reset, straight from a flop
//   pad_in_i     : raw pad inputs (2-flop synchronized internally)
//   pad_ovr_o    : 1 = pad driven by the host override
//   pad_out_o    : host output value per pad
//   pad_oeb_o    : host output-enable-bar per pad
// Register map (offset): 00 CTRL, 04/08 OVR, 0C/10 OUT, 14/18 OEB,
// 1C/20 IN (ro), 24 STATUS (ro). HI registers hold pads [NPADS-1:32].
module io_pad_ctrl #(
    parameter int unsigned NPADS      = 38,
    parameter int unsigned RST_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    io_pad_ctrl_if.slave     wbs,
    output logic             soc_rst_no,
    input  logic [NPADS-1:0] pad_in_i,
    output logic [NPADS-1:0] pad_ovr_o,
    output logic [NPADS-1:0] pad_out_o,
    output logic [NPADS-1:0] pad_oeb_o
);

    localparam int unsigned HI_W     = NPADS - 32;
    localparam logic [7:0]  CNT_LAST = 8'(RST_CYCLES - 1);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_OVR_LO = 8'h04;
    localparam logic [7:0] OFF_OVR_HI = 8'h08;
    localparam logic [7:0] OFF_OUT_LO = 8'h0C;
    localparam logic [7:0] OFF_OUT_HI = 8'h10;
    localparam logic [7:0] OFF_OEB_LO = 8'h14;
    localparam logic [7:0] OFF_OEB_HI = 8'h18;
    localparam logic [7:0] OFF_IN_LO  = 8'h1C;
    localparam logic [7:0] OFF_IN_HI  = 8'h20;
    localparam logic [7:0] OFF_STATUS = 8'h24;

    typedef enum logic [1:0] {ST_HOLD, ST_COUNT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ctrl_run;
    logic [NPADS-1:0] sync1_q, sync2_q;
    logic [31:0]      rdata;
    logic [7:0]       off;
    logic             acc, wr, wr_srst;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    // ~ack blocks a new access in the ack cycle, so a held strobe completes
    // every second cycle.
    assign off     = wbs.wbs_adr_i[7:0];
    assign acc     = wbs.wbs_stb_i && wbs.wbs_cyc_i && !wbs.wbs_ack_o &&
                     (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr      = acc && wbs.wbs_we_i;
    assign wr_srst = wr && (off == OFF_CTRL) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[1];

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata = {31'b0, ctrl_run};
            OFF_OVR_LO: rdata = pad_ovr_o[31:0];
            OFF_OVR_HI: rdata = 32'(pad_ovr_o[NPADS-1:32]);
            OFF_OUT_LO: rdata = pad_out_o[31:0];
            OFF_OUT_HI: rdata = 32'(pad_out_o[NPADS-1:32]);
            OFF_OEB_LO: rdata = pad_oeb_o[31:0];
            OFF_OEB_HI: rdata = 32'(pad_oeb_o[NPADS-1:32]);
            OFF_IN_LO:  rdata = sync2_q[31:0];
            OFF_IN_HI:  rdata = 32'(sync2_q[NPADS-1:32]);
            OFF_STATUS: rdata = {16'b0, cnt_q, 7'b0, state_q == ST_RUN};
            default:    rdata = '0;
        endcase
    end

    // Reset sequencer. A soft reset overrides everything for one cycle; the
    // counter is cleared whenever the FSM is not staying in COUNT, so STATUS
    // shows 0 once running.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_HOLD:  if (ctrl_run) state_d = ST_COUNT;
            ST_COUNT: begin
                if (!ctrl_run)              state_d = ST_HOLD;
                else if (cnt_q == CNT_LAST) state_d = ST_RUN;
                else                        cnt_d   = cnt_q + 8'd1;
            end
            ST_RUN:   if (!ctrl_run) state_d = ST_HOLD;
            default:  state_d = ST_HOLD;
        endcase
        if (wr_srst) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            soc_rst_no    <= 1'b0;
            ctrl_run      <= 1'b0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            pad_ovr_o     <= '0;
            pad_out_o     <= '0;
            pad_oeb_o     <= '1;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            soc_rst_no    <= (state_d == ST_RUN);
            sync1_q       <= pad_in_i;
            sync2_q       <= sync1_q;
            wbs.wbs_ack_o <= acc;
            wbs.wbs_dat_o <= (acc && !wbs.wbs_we_i) ? rdata : '0;
            if (wr) begin
                case (off)
                    OFF_CTRL:   if (wbs.wbs_sel_i[0]) ctrl_run <= wbs.wbs_dat_i[0];
                    OFF_OVR_LO: pad_ovr_o[31:0] <= merge(pad_ovr_o[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
                    OFF_OVR_HI: pad_ovr_o[NPADS-1:32] <= HI_W'(merge(32'(pad_ovr_o[NPADS-1:32]),
                                                                     wbs.wbs_dat_i, wbs.wbs_sel_i));
                    OFF_OUT_LO: pad_out_o[31:0] <= merge(pad_out_o[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
                    OFF_OUT_HI: pad_out_o[NPADS-1:32] <= HI_W'(merge(32'(pad_out_o[NPADS-1:32]),
                                                                     wbs.wbs_dat_i, wbs.wbs_sel_i));
                    OFF_OEB_LO: pad_oeb_o[31:0] <= merge(pad_oeb_o[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
                    OFF_OEB_HI: pad_oeb_o[NPADS-1:32] <= HI_W'(merge(32'(pad_oeb_o[NPADS-1:32]),
                                                                     wbs.wbs_dat_i, wbs.wbs_sel_i));
                    default: ;
                endcase
            end
        end
    end

endmodule
